// File: rtl/spi_master_link_pkg.sv
// Shared SPI link definitions: FSM state encoding and the bus mode constants
// used by both the master and the slave receiver.
package spi_master_link_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_link_if.sv
// Request/response handshake between the ALU/flag side and the SPI master.
//  tx_data/tx_valid  : word to send and request (master -> link)
//  tx_ready/busy     : link state (link -> master)
//  rx_data/rx_valid  : received word and its 1-cycle update strobe
interface spi_master_link_if #(
  parameter int FRAME_W = 8
);
  logic [FRAME_W-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;

  modport master (output tx_data, tx_valid,
                  input  tx_ready, busy, rx_data, rx_valid);
  modport slave  (input  tx_data, tx_valid,
                  output tx_ready, busy, rx_data, rx_valid);
endinterface

// File: rtl/spi_master_link_clk_div.sv
// SCLK generator. Counts clk cycles only while enabled (XFER) and toggles
// sclk every CLK_DIV cycles, flagging which edge the toggle produces.
//  clk, reset : system clock, async active-high reset
//  en         : run the divider; when low the count and sclk are parked at idle
//  sclk       : registered SPI clock
//  rise_tick  : high in the cycle whose clk edge drives sclk high
//  fall_tick  : high in the cycle whose clk edge drives sclk low
module spi_master_link_clk_div
  import spi_master_link_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int DW = $clog2(CLK_DIV) + 1;

  logic [DW-1:0] div;
  logic          tc;

  assign tc        = en && (div == DW'(CLK_DIV - 1));
  assign rise_tick = tc && !sclk;
  assign fall_tick = tc &&  sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= '0;
      sclk <= SPI_CPOL;
    end else if (!en) begin
      div  <= '0;
      sclk <= SPI_CPOL;
    end else if (tc) begin
      div  <= '0;
      sclk <= ~sclk;
    end else begin
      div  <= div + DW'(1);
    end
  end
endmodule

// File: rtl/spi_master_link.sv
// SPI mode-0 master. Sends one FRAME_W-bit word MSB first on mosi and
// captures the peripheral's word from miso in the same frame.
//  clk, reset : system clock, async active-high reset
//  bus        : request/response handshake (slave modport)
//  sclk       : SPI clock, idle low
//  mosi       : SPI data out
//  miso       : SPI data in (sampled on the edge that drives sclk high)
//  ss_n       : chip select, active low
module spi_master_link
  import spi_master_link_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int FRAME_W  = 8,
  parameter int CS_SETUP = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_link_if.slave    bus,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                ss_n
);
  localparam int CW = $clog2(CS_SETUP) + 1;
  localparam int BW = $clog2(FRAME_W) + 1;

  spi_state_t         state;
  logic [CW-1:0]      cs_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] tx_shift;
  logic [FRAME_W-1:0] rx_shift;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic               xfer_en;
  logic               rise_tick;
  logic               fall_tick;

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign xfer_en      = (state == XFER);

  spi_master_link_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .en        (xfer_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cs_cnt   <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // tx_ready is implied by being in IDLE
          if (bus.tx_valid) begin
            state    <= SETUP;
            cs_cnt   <= '0;
            bit_cnt  <= '0;
            tx_shift <= bus.tx_data;
            ss_n     <= 1'b0;
            mosi     <= bus.tx_data[FRAME_W-1];
          end
        end
        SETUP: begin
          if (cs_cnt == CW'(CS_SETUP - 1)) begin
            state  <= XFER;
            cs_cnt <= '0;
          end else begin
            cs_cnt <= cs_cnt + CW'(1);
          end
        end
        XFER: begin
          if (rise_tick) begin
            rx_shift <= {rx_shift[FRAME_W-2:0], miso};
            bit_cnt  <= bit_cnt + BW'(1);
          end
          // bit_cnt already counts the rise just finished; the fall after the
          // last rise ends the transfer with sclk back low.
          if (fall_tick) begin
            if (bit_cnt < BW'(FRAME_W)) begin
              mosi     <= tx_shift[FRAME_W-2];
              tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end else begin
              state  <= HOLD;
              cs_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (cs_cnt == CW'(CS_SETUP - 1)) begin
            state    <= IDLE;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            cs_cnt <= cs_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_link.sv
// Directed bench for spi_master_link: a clk-domain mode-0 slave model on the
// default instance plus a second instance with a fast divider.
module tb_spi_master_link;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_link_if #(.FRAME_W(8)) bus  ();
  spi_master_link_if #(.FRAME_W(8)) bus2 ();

  logic sclk, mosi, miso, ss_n;
  logic sclk2, mosi2, ss_n2;

  spi_master_link dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  spi_master_link #(.CLK_DIV(2), .FRAME_W(8), .CS_SETUP(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .sclk(sclk2), .mosi(mosi2), .miso(1'b1), .ss_n(ss_n2)
  );

  // Slave model: reloads its word while deselected, shifts out on sclk falls,
  // captures mosi on sclk rises, logs full frames when ss_n rises.
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] s_log [0:15];
  logic       sclk_q = 1'b0;
  logic       ss_q   = 1'b1;
  int         s_rises   = 0;
  int         n_frames  = 0;
  int         n_partial = 0;

  assign miso = s_sh[7];

  always @(posedge clk) begin
    sclk_q <= sclk;
    ss_q   <= ss_n;
    if (ss_n) begin
      s_sh    <= s_tx;
      s_rises <= 0;
    end else begin
      if (!sclk_q && sclk) begin
        s_rx    <= {s_rx[6:0], mosi};
        s_rises <= s_rises + 1;
      end
      if (sclk_q && !sclk) s_sh <= {s_sh[6:0], 1'b0};
    end
    if (!ss_q && ss_n) begin
      if (s_rises == 8) begin
        s_log[n_frames[3:0]] <= s_rx;
        n_frames <= n_frames + 1;
      end else begin
        n_partial <= n_partial + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic start(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Cycles from the accept edge to the rx_valid edge (1000 on timeout).
  task automatic wait_rx(output int cyc);
    cyc = 0;
    while (!bus.rx_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int   cyc;
  logic seen;
  logic prev2;
  int   r1, r2, nr;
  logic [7:0] w2;

  initial begin
    reset = 1'b1;
    bus.tx_valid  = 1'b0; bus.tx_data  = 8'h00;
    bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00;
    s_tx = 8'h3C;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_ss_n", ss_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_tx_ready", bus.tx_ready, 1'b1);
    chk("rst_rx_data", bus.rx_data, 8'h00);

    // 2: single frame A5 out, 3C back
    start(8'hA5);
    chk("t2_busy", bus.busy, 1'b1);
    chk("t2_tx_ready", bus.tx_ready, 1'b0);
    chk("t2_ss_n", ss_n, 1'b0);
    chk("t2_mosi_msb", mosi, 1'b1);
    wait_rx(cyc);
    chk("t2_latency", cyc, 68);
    chk("t2_rx_data", bus.rx_data, 8'h3C);
    chk("t2_ss_n_end", ss_n, 1'b1);
    @(negedge clk);
    chk("t2_rx_valid_pulse", bus.rx_valid, 1'b0);
    chk("t2_frames", n_frames, 1);
    chk("t2_slave_word", s_log[0], 8'hA5);
    chk("t2_partial", n_partial, 0);

    // 3: back-to-back with tx_valid held
    bus.tx_data  = 8'h0F;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    chk("t3_busy1", bus.busy, 1'b1);
    bus.tx_data = 8'hF0;
    s_tx = 8'h96;
    wait_rx(cyc);
    chk("t3_latency1", cyc, 68);
    chk("t3_rx_data1", bus.rx_data, 8'h3C);
    chk("t3_gap_high", ss_n, 1'b1);
    @(negedge clk);
    chk("t3_gap_low", ss_n, 1'b0);
    chk("t3_busy2", bus.busy, 1'b1);
    chk("t3_mosi2", mosi, 1'b1);
    bus.tx_valid = 1'b0;
    wait_rx(cyc);
    chk("t3_latency2", cyc, 68);
    chk("t3_rx_data2", bus.rx_data, 8'h96);
    @(negedge clk);
    chk("t3_frames", n_frames, 3);
    chk("t3_word1", s_log[1], 8'h0F);
    chk("t3_word2", s_log[2], 8'hF0);

    // 4: request while busy is ignored
    s_tx = 8'h5A;
    start(8'h12);
    repeat (10) @(negedge clk);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_rx(cyc);
    chk("t4_latency", cyc, 68 - 11);
    chk("t4_rx_data", bus.rx_data, 8'h5A);
    @(negedge clk);
    chk("t4_frames", n_frames, 4);
    chk("t4_word", s_log[3], 8'h12);
    repeat (100) @(negedge clk);
    chk("t4_no_extra", n_frames, 4);
    chk("t4_idle_ss_n", ss_n, 1'b1);
    chk("t4_idle_busy", bus.busy, 1'b0);

    // 5: reset mid-frame
    start(8'hFF);
    repeat (20) @(negedge clk);
    chk("t5_pre_ss_n", ss_n, 1'b0);
    chk("t5_pre_mosi", mosi, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_ss_n", ss_n, 1'b1);
    chk("t5_sclk", sclk, 1'b0);
    chk("t5_mosi", mosi, 1'b0);
    chk("t5_rx_data", bus.rx_data, 8'h00);
    chk("t5_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen = seen | bus.rx_valid;
    end
    chk("t5_no_rx_valid", seen, 1'b0);
    chk("t5_partial", n_partial, 1);
    s_tx = 8'hC7;
    start(8'h81);
    wait_rx(cyc);
    chk("t5_latency", cyc, 68);
    chk("t5_rx_data2", bus.rx_data, 8'hC7);
    @(negedge clk);
    chk("t5_frames", n_frames, 5);
    chk("t5_word", s_log[4], 8'h81);

    // 6: CLK_DIV=2, CS_SETUP=1 instance
    bus2.tx_data  = 8'hC3;
    bus2.tx_valid = 1'b1;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    cyc = 0; prev2 = sclk2; r1 = -1; r2 = -1; nr = 0; w2 = 8'h00;
    while (!bus2.rx_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (!prev2 && sclk2) begin
        if (nr == 0) r1 = cyc;
        if (nr == 1) r2 = cyc;
        nr++;
        w2 = {w2[6:0], mosi2};
      end
      prev2 = sclk2;
    end
    chk("t6_latency", cyc, 34);
    chk("t6_first_rise", r1, 3);
    chk("t6_period", r2 - r1, 4);
    chk("t6_pulses", nr, 8);
    chk("t6_mosi_word", w2, 8'hC3);
    chk("t6_rx_data", bus2.rx_data, 8'hFF);
    chk("t6_ss_n", ss_n2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
